// File: rtl/register32_8_reader_if.sv
// Burst-read bus between a requester/consumer and register32_8_reader.
// Optional macro READ_PARITY_EN adds the d_par beat-parity signal.
//
// Handshake: a transfer on either channel happens only at a rising clk edge
// where valid and ready are both 1 (request: rd_req/rd_ready, data:
// d_valid/d_ready). The reader never lowers d_valid or changes d_out/d_last
// until the beat is taken; the requester holds rd_addr/rd_len with rd_req.
interface register32_8_reader_if #(
  parameter int WIDTH = 32
);
  logic             rd_req;
  logic [2:0]       rd_addr;
  logic [2:0]       rd_len;
  logic             rd_ready;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             d_ready;
  logic             d_last;
  logic             busy;
`ifdef READ_PARITY_EN
  logic             d_par;
`endif

  // Reader side.
  modport slave (
    input  rd_req,
    input  rd_addr,
    input  rd_len,
    input  d_ready,
    output rd_ready,
    output d_out,
    output d_valid,
    output d_last,
`ifdef READ_PARITY_EN
    output d_par,
`endif
    output busy
  );

  // Requester / consumer side.
  modport master (
    output rd_req,
    output rd_addr,
    output rd_len,
    output d_ready,
    input  rd_ready,
    input  d_out,
    input  d_valid,
    input  d_last,
`ifdef READ_PARITY_EN
    input  d_par,
`endif
    input  busy
  );
endinterface

// File: rtl/register32_8_reader.sv
// Burst reader over an eight-entry register file.
// A request (start index, length-1) is accepted in IDLE; the reader then
// streams one snapshot word per accepted beat, wrapping the index modulo 8,
// and flags the final beat with d_last.
// Optional macro READ_PARITY_EN: adds d_par, the XOR of the d_out bits,
// registered together with d_out.
module register32_8_reader #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            d_in0,
  input  logic [WIDTH-1:0]            d_in1,
  input  logic [WIDTH-1:0]            d_in2,
  input  logic [WIDTH-1:0]            d_in3,
  input  logic [WIDTH-1:0]            d_in4,
  input  logic [WIDTH-1:0]            d_in5,
  input  logic [WIDTH-1:0]            d_in6,
  input  logic [WIDTH-1:0]            d_in7,
  register32_8_reader_if.slave        bus,
  output logic                        o_dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;

  state_t           w_state_nxt;
  logic [2:0]       w_ptr_nxt;
  logic [2:0]       w_cnt_nxt;
  logic             w_valid_nxt;
  logic             w_load;
  logic [2:0]       w_sel_idx;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_beat_take;

`ifdef READ_PARITY_EN
  logic             r_par;
`endif

  // Register-file read mux: selects the word to snapshot into d_out.
  always_comb begin
    w_sel_data = d_in0;
    case (w_sel_idx)
      3'd0: w_sel_data = d_in0;
      3'd1: w_sel_data = d_in1;
      3'd2: w_sel_data = d_in2;
      3'd3: w_sel_data = d_in3;
      3'd4: w_sel_data = d_in4;
      3'd5: w_sel_data = d_in5;
      3'd6: w_sel_data = d_in6;
      3'd7: w_sel_data = d_in7;
      default: w_sel_data = d_in0;
    endcase
  end

  // A beat leaves only when it is actually presented; d_ready alone is inert.
  assign w_beat_take = r_valid && bus.d_ready;

  // Next-state logic: request capture in IDLE, beat advance in BURST.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    w_sel_idx   = r_ptr;
    case (r_state)
      IDLE: begin
        if (bus.rd_req) begin
          w_ptr_nxt   = bus.rd_addr;
          w_cnt_nxt   = bus.rd_len;
          w_sel_idx   = bus.rd_addr;
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        // rd_req is deliberately not looked at here: requests during a
        // burst are ignored, not queued.
        if (w_beat_take) begin
          if (r_cnt != 3'd0) begin
            // 3-bit increment gives the 7 -> 0 wrap for free.
            w_ptr_nxt = r_ptr + 3'd1;
            w_cnt_nxt = r_cnt - 3'd1;
            w_sel_idx = r_ptr + 3'd1;
            w_load    = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, pointer/count and the d_out snapshot register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      r_cnt   <= 3'd0;
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      // d_out only changes on a load, so it stays frozen across a stall
      // even if the register file changes underneath it.
      if (w_load) begin
        r_dout <= w_sel_data;
      end
    end
  end

`ifdef READ_PARITY_EN
  // Parity travels with the snapshot so it is stable under stall as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^w_sel_data;
    end
  end

  assign bus.d_par = r_par;
`endif

  assign bus.rd_ready = (r_state == IDLE);
  assign bus.busy     = (r_state == BURST);
  assign bus.d_valid  = r_valid;
  assign bus.d_out    = r_dout;
  assign bus.d_last   = r_valid && (r_cnt == 3'd0);
  assign o_dbg_state  = r_state;

endmodule

// File: doc/register32_8_reader.md
REGISTER32_8_READER -- requirements
Module: register32_8_reader

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data width of each register word and of d_out.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: d_in0..d_in7  input  WIDTH each  current contents of the eight file registers.
REQ-005 SHALL have port: rd_req  input  1  burst read request, valid with rd_addr/rd_len.
REQ-006 SHALL have port: rd_addr  input  3  start register index.
REQ-007 SHALL have port: rd_len  input  3  burst length minus one (0 = 1 word, 7 = 8 words).
REQ-008 SHALL have port: rd_ready  output  1  request accepted when rd_req && rd_ready at a clk edge.
REQ-009 SHALL have port: d_out  output  WIDTH  read data beat.
REQ-010 SHALL have port: d_valid  output  1  d_out holds a valid beat.
REQ-011 SHALL have port: d_ready  input  1  downstream accepts beat when d_valid && d_ready at a clk edge.
REQ-012 SHALL have port: d_last  output  1  current beat is the final beat of the burst.
REQ-013 SHALL have port: busy  output  1  burst in progress (state BURST).

Function
REQ-014 SHALL implement FSM with states IDLE and BURST; rd_ready = 1 only in IDLE, busy = 1 only in BURST.
REQ-015 IDLE: on request accept, SHALL capture rd_addr as pointer and rd_len as remaining count, load d_out with d_in[rd_addr], assert d_valid, and enter BURST on the same edge.
REQ-016 First beat SHALL appear exactly one cycle after the accepting edge; no request is dropped or queued.
REQ-017 d_out SHALL be a snapshot taken when the beat is loaded; it SHALL stay stable while d_valid && !d_ready, even if d_in* change.
REQ-018 On a beat accept with count > 0: pointer increments modulo 8 (7 wraps to 0), count decrements, d_out reloads from d_in[new pointer], d_valid stays 1 -- one beat per cycle when d_ready held high.
REQ-019 d_last SHALL be 1 exactly when d_valid = 1 and count = 0.
REQ-020 On a beat accept with count = 0: d_valid and d_last SHALL go 0, FSM returns to IDLE; rd_ready is 1 the following cycle.
REQ-021 rd_req while in BURST SHALL be ignored without effect on the current burst.
REQ-022 d_ready while d_valid = 0 SHALL have no effect.
REQ-023 d_ready held low indefinitely SHALL hold all outputs unchanged (no timeout).

Reset
REQ-024 reset high at a clk edge SHALL force IDLE, d_out = 0, d_valid = 0, d_last = 0, busy = 0, pointer = 0, count = 0; rd_ready = 1 after that edge.
REQ-025 reset mid-burst SHALL abort the burst with no further beats; rd_req sampled in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 Macro READ_PARITY_EN defined: SHALL add output d_par (1 bit) = XOR of all d_out bits, registered with d_out, 0 at reset, stable with d_out under stall.
REQ-027 Macro READ_PARITY_EN undefined: d_par port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Single read: regs = 0x1000_000i, rd_addr=3, rd_len=0, d_ready=1 -> one beat 0x1000_0003 with d_last=1 one cycle after accept, rd_ready=1 the cycle after.
REQ-029 Wrap burst: rd_addr=6, rd_len=3, d_ready=1 -> beats 6,7,0,1 on consecutive cycles, d_last only on reg 1.
REQ-030 Stall/snapshot: burst rd_addr=0, rd_len=1, d_ready=0 for 5 cycles while d_in0 changes 0xAAAA_AAAA -> 0x5555_5555 -> d_out holds 0xAAAA_AAAA until d_ready=1.
REQ-031 Busy ignore: rd_req with rd_addr=5 during 8-beat burst from 0 -> beats 0..7 unaffected, no extra beats.
REQ-032 Reset mid-burst: reset asserted after beat 2 of an 8-beat burst -> next cycle d_valid=0, d_out=0, busy=0, rd_ready=1.
REQ-033 With READ_PARITY_EN: d_out = 0x0000_0007 -> d_par=1; d_out = 0x0000_0003 -> d_par=0.
